// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received-word handshake and sticky error flags of uart_rx_param
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 ovr_err;
  logic                 par_err;
  logic                 err_clr;

  modport master (
    output data, data_valid, frame_err, ovr_err, par_err,
    input  data_ready, err_clr
  );

  modport slave (
    input  data, data_valid, frame_err, ovr_err, par_err,
    output data_ready, err_clr
  );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with majority-vote sampling and sticky error flags
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic            rx,
  uart_rx_param_if.master rx_if
);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMP_0   = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] SAMP_1   = CNT_W'(H);
  localparam logic [CNT_W-1:0] SAMP_2   = CNT_W'(H + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_param: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 rxs_prev_q, rxs_prev_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 perr_set;
`endif

  logic rxs;
  logic maj;
  logic cnt_wrap;
  logic decide;
  logic commit;
  logic ferr_set;
  logic ovr_set;

  assign rxs      = sync2_q;
  assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign cnt_wrap = (cnt_q == CNT_LAST);
  assign decide   = (cnt_q == SAMP_2);

  always_comb begin
    state_d    = state_q;
    sync1_d    = rx;
    sync2_d    = sync1_q;
    rxs_prev_d = sync2_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    samp_d     = samp_q;
    word_d     = word_q;
    data_d     = data_q;
    valid_d    = valid_q;
    commit     = 1'b0;
    ferr_set   = 1'b0;
    ovr_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set   = 1'b0;
`endif

    if (state_q != ST_IDLE && state_q != ST_BREAK) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    end
    if (cnt_q == SAMP_0) samp_d[0] = rxs;
    if (cnt_q == SAMP_1) samp_d[1] = rxs;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs) state_d = ST_START;
      end
      ST_START: begin
        if (decide && maj) begin
          state_d = ST_IDLE;
        end else if (cnt_wrap) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (decide) word_d[bit_idx_q] = maj;
        if (cnt_wrap) begin
          if (bit_idx_q == IDX_LAST) begin
            stop_idx_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (decide && (maj != ((^word_q) ^ 1'(PARITY_ODD)))) perr_set = 1'b1;
        if (cnt_wrap) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (decide) begin
          if (!maj) ferr_set = 1'b1;
          // Re-arm at the final decision point so a short stop bit cannot hide the next start edge.
          if (stop_idx_q == STOP_LAST) begin
            commit  = 1'b1;
            state_d = rxs ? ST_IDLE : ST_BREAK;
          end
        end
        if (cnt_wrap) stop_idx_d = 1'b1;
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (valid_q && rx_if.data_ready) valid_d = 1'b0;
    if (commit) begin
      if (!valid_q || rx_if.data_ready) begin
        data_d  = word_q;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    ferr_d = rx_if.err_clr ? 1'b0 : (ferr_q | ferr_set);
    ovr_d  = rx_if.err_clr ? 1'b0 : (ovr_q | ovr_set);
`ifdef UART_RX_PARITY_EN
    perr_d = rx_if.err_clr ? 1'b0 : (perr_q | perr_set);
`endif
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      samp_q     <= 2'b11;
      word_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rxs_prev_q <= rxs_prev_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      samp_q     <= samp_d;
      word_q     <= word_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx_if.data       = data_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.ovr_err    = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.par_err    = perr_q;
`else
  assign rx_if.par_err    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param against a word-level model
module tb_uart_rx_param;
  localparam int CPB = 104;
  localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int DB = 7;
  localparam int SB = 2;
`else
  localparam int DB = 8;
  localparam int SB = 1;
`endif

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic rx = 1'b1;
  logic rdy = 1'b0;
  logic eclr = 1'b0;

  uart_rx_param_if #(.DATA_BITS(DB)) u_if ();
  assign u_if.data_ready = rdy;
  assign u_if.err_clr    = eclr;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB),
    .PARITY_ODD  (0)
  ) dut (
    .clk    (clk),
    .clear_n(clear_n),
    .rx     (rx),
    .rx_if  (u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [DB-1:0] m_data = '0;
  logic          m_valid = 1'b0;
  logic          m_ferr = 1'b0;
  logic          m_ovr = 1'b0;
  logic          m_perr = 1'b0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] rcv_q[$];

  always @(negedge clk) begin
    if (u_if.data_valid && u_if.data_ready) rcv_q.push_back(u_if.data);
  end

  function automatic logic [DB+3:0] dut_vec();
    return {u_if.data_valid, u_if.data, u_if.frame_err, u_if.ovr_err, u_if.par_err};
  endfunction

  function automatic logic [DB+3:0] mdl_vec();
    return {m_valid, m_data, m_ferr, m_ovr, m_perr};
  endfunction

  task automatic send_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame and applies its effect to the word-level model once the frame has ended.
  task automatic send_frame(input logic [DB-1:0] w, input logic stop_lvl, input logic bad_par,
                            input int stop_len);
    send_bit(1'b0, CPB);
    for (int i = 0; i < DB; i++) send_bit(w[i], CPB);
`ifdef UART_RX_PARITY_EN
    send_bit((^w) ^ bad_par, CPB);
    if (bad_par) m_perr = 1'b1;
`endif
    for (int s = 0; s < SB; s++) send_bit(stop_lvl, (s == SB - 1) ? stop_len : CPB);
    if (!stop_lvl) m_ferr = 1'b1;
    if (rdy) begin
      m_data = w;
      exp_q.push_back(w);
    end else if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = w;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic consume();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic clear_errs();
    eclr = 1'b1;
    @(negedge clk);
    eclr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    repeat (3) @(negedge clk);
    clear_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL reset_state: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
  endtask

  task automatic test_basic();
    send_frame(DB'(9'h055), 1'b1, 1'b0, CPB);
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL basic_55: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
  endtask

  task automatic test_overrun();
    send_frame(DB'(9'h0A3), 1'b1, 1'b0, CPB);
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL overrun: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
    consume();
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL consume: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
    clear_errs();
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL err_clr: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
  endtask

  task automatic test_start_glitch();
    send_bit(1'b0, 30);
    send_bit(1'b1, 2 * CPB);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL glitch_idle: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
    send_frame(DB'(9'h03C), 1'b1, 1'b0, CPB);
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL glitch_next: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
    consume();
  endtask

  task automatic test_break();
    send_frame(DB'(9'h0C5), 1'b0, 1'b0, CPB);
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL break_word: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
    consume();
    send_bit(1'b0, 500 - CPB - 3);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL break_hold: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
    send_bit(1'b1, 2 * CPB);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL break_release: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
    clear_errs();
  endtask

  // One-clock high pulse aligned to the middle sample of data bit 3 of an all-zero word.
  task automatic test_majority();
    send_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) send_bit(1'b0, CPB);
    send_bit(1'b0, H + 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, CPB - H - 2);
    for (int i = 4; i < DB; i++) send_bit(1'b0, CPB);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0, CPB);
`endif
    for (int s = 0; s < SB; s++) send_bit(1'b1, CPB);
    m_valid = 1'b1;
    m_data  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL majority: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
    consume();
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      logic [DB-1:0] w;
      w = DB'($urandom);
      send_bit(1'b1, $urandom_range(1, 300));
      send_frame(w, 1'b1, 1'b0, CPB);
      repeat (2) @(negedge clk);
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL random_%0d: got %h expected %h", n, dut_vec(), mdl_vec());
      else passed++;
      consume();
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    rcv_q.delete();
    rdy = 1'b1;
    for (int n = 0; n < 5; n++) send_frame(DB'($urandom), 1'b1, 1'b0, H + 12);
    send_bit(1'b1, CPB);
    rdy = 1'b0;
    checks++;
    if (rcv_q.size() !== exp_q.size())
      $display("FAIL b2b_count: got %0d expected %0d", rcv_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      checks++;
      if (rcv_q[i] !== exp_q[i]) $display("FAIL b2b_word_%0d: got %h expected %h", i, rcv_q[i], exp_q[i]);
      else passed++;
    end
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL b2b_final: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(DB'(9'h041), 1'b1, 1'b1, CPB);
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL parity_bad: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
    clear_errs();
    consume();
    send_frame(DB'(9'h041), 1'b1, 1'b0, CPB);
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL parity_good: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
  endtask
`endif

  task automatic test_reset_mid_frame();
    send_frame(DB'(9'h05A), 1'b1, 1'b0, CPB);
    send_frame(DB'(9'h0B4), 1'b0, 1'b0, CPB);
    send_bit(1'b1, 2 * CPB);
    send_bit(1'b0, CPB);
    send_bit(1'b1, CPB);
    send_bit(1'b0, H);
    #3 clear_n = 1'b0;
    m_data = '0;
    m_valid = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    m_perr = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL reset_mid: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
    rx = 1'b1;
    @(negedge clk);
    clear_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checks++;
    if (dut_vec() !== mdl_vec()) $display("FAIL reset_no_word: got %h expected %h", dut_vec(), mdl_vec());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_start_glitch();
    test_break();
    test_majority();
    test_random();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
